tour_seq: RTL and testbench



---
 rtl/tour_pkg.sv | 42 ++++
 rtl/tour_move_decode.sv | 39 +++
 rtl/tour_seq.sv | 158 +++++++++++++++
 tb/tb_tour_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour sequencer.
package tour_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    IDLE,
    GO,
    SOLVE,
    FETCH,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H,
    FAULT
  } tseq_state_t;

  // Motion opcodes: plain move for the Y leg, move + fanfare for the X leg
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  // Motion headings
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // One-hot move codes from the solver (dx,dy in the trailing comment)
  localparam logic [7:0] MV_B0 = 8'h01;  // +1,+2
  localparam logic [7:0] MV_B1 = 8'h02;  // -1,+2
  localparam logic [7:0] MV_B2 = 8'h04;  // -2,+1
  localparam logic [7:0] MV_B3 = 8'h08;  // -2,-1
  localparam logic [7:0] MV_B4 = 8'h10;  // -1,-2
  localparam logic [7:0] MV_B5 = 8'h20;  // +1,-2
  localparam logic [7:0] MV_B6 = 8'h40;  // +2,-1
  localparam logic [7:0] MV_B7 = 8'h80;  // +2,+1

  // True when exactly one bit of v is set
  function automatic logic f_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Turns one one-hot knight move into its Y-leg and X-leg motion commands.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  i_move,
  output logic [15:0] o_vert_cmd,
  output logic [15:0] o_horz_cmd,
  output logic        o_legal
);

  logic [1:0] w_dx_mag;
  logic       w_dx_neg;
  logic [1:0] w_dy_mag;
  logic       w_dy_neg;

  // Split the move into magnitude/sign per axis; anything not one-hot is illegal
  always_comb begin
    w_dx_mag = 2'd0;
    w_dx_neg = 1'b0;
    w_dy_mag = 2'd0;
    w_dy_neg = 1'b0;
    o_legal  = 1'b1;
    case (i_move)
      MV_B0: begin w_dx_mag = 2'd1;                  w_dy_mag = 2'd2;                  end
      MV_B1: begin w_dx_mag = 2'd1; w_dx_neg = 1'b1; w_dy_mag = 2'd2;                  end
      MV_B2: begin w_dx_mag = 2'd2; w_dx_neg = 1'b1; w_dy_mag = 2'd1;                  end
      MV_B3: begin w_dx_mag = 2'd2; w_dx_neg = 1'b1; w_dy_mag = 2'd1; w_dy_neg = 1'b1; end
      MV_B4: begin w_dx_mag = 2'd1; w_dx_neg = 1'b1; w_dy_mag = 2'd2; w_dy_neg = 1'b1; end
      MV_B5: begin w_dx_mag = 2'd1;                  w_dy_mag = 2'd2; w_dy_neg = 1'b1; end
      MV_B6: begin w_dx_mag = 2'd2;                  w_dy_mag = 2'd1; w_dy_neg = 1'b1; end
      MV_B7: begin w_dx_mag = 2'd2;                  w_dy_mag = 2'd1;                  end
      default: o_legal = 1'b0;
    endcase
  end

  assign o_vert_cmd = {OP_MOVE,    (w_dy_neg ? HDG_S : HDG_N), {2'b00, w_dy_mag}};
  assign o_horz_cmd = {OP_FANFARE, (w_dx_neg ? HDG_W : HDG_E), {2'b00, w_dx_mag}};

endmodule

// File: rtl/tour_seq.sv
// Sequencer: launches the knight's-tour solver, then replays each move as a
// Y-leg and an X-leg motion command with a response wait after each.
module tour_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int TMO_W     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [2:0]  i_x_start,
  input  logic [2:0]  i_y_start,
  output logic [2:0]  o_solve_x,
  output logic [2:0]  o_solve_y,
  output logic        o_solve_go,
  input  logic        i_solve_done,
  output logic [4:0]  o_indx,
  input  logic [7:0]  i_move,
  output logic [15:0] o_cmd,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  input  logic        i_resp,
  output logic        o_busy,
  output logic        o_tour_cmplt,
  output logic        o_fault
);

  // The timer expires on the cycle it would step onto all-ones, so a wait
  // state lasts at most 2^TMO_W-1 cycles before FAULT becomes visible.
  localparam logic [TMO_W-1:0] TMO_LAST = ~(TMO_W'(1));
  localparam logic [4:0]       LAST_IDX = 5'(NUM_MOVES - 1);

  tseq_state_t      r_state;
  tseq_state_t      w_state_next;
  logic [TMO_W-1:0] r_timer;
  logic [4:0]       r_indx;
  logic [7:0]       r_move;
  logic [2:0]       r_solve_x;
  logic [2:0]       r_solve_y;
  logic             r_tour_cmplt;

  logic             w_load_start;
  logic             w_indx_clr;
  logic             w_indx_inc;
  logic             w_cmplt;
  logic             w_tmo;
  logic             w_timing;
  logic [15:0]      w_vert_cmd;
  logic [15:0]      w_horz_cmd;
  logic             w_legal;

  tour_move_decode u_decode (
    .i_move     (r_move),
    .o_vert_cmd (w_vert_cmd),
    .o_horz_cmd (w_horz_cmd),
    .o_legal    (w_legal)
  );

  assign w_tmo    = (r_timer == TMO_LAST);
  assign w_timing = (r_state == SOLVE) || (r_state == WAIT_V) || (r_state == WAIT_H);

  // Next-state logic; done/resp take priority over a same-cycle timeout
  always_comb begin
    w_state_next = r_state;
    w_load_start = 1'b0;
    w_indx_clr   = 1'b0;
    w_indx_inc   = 1'b0;
    w_cmplt      = 1'b0;
    case (r_state)
      IDLE, FAULT: begin
        if (i_start) begin
          w_state_next = GO;
          w_load_start = 1'b1;
        end
      end
      GO: w_state_next = SOLVE;
      SOLVE: begin
        if (i_solve_done) begin
          w_state_next = FETCH;
          w_indx_clr   = 1'b1;
        end else if (w_tmo) begin
          w_state_next = FAULT;
        end
      end
      FETCH: w_state_next = f_onehot8(i_move) ? VERT : FAULT;
      VERT: begin
        // move_r was checked in FETCH; an illegal value here means corruption
        if (!w_legal)        w_state_next = FAULT;
        else if (i_cmd_rdy)  w_state_next = WAIT_V;
      end
      WAIT_V: begin
        if (i_resp)     w_state_next = HORZ;
        else if (w_tmo) w_state_next = FAULT;
      end
      HORZ: begin
        if (i_cmd_rdy) w_state_next = WAIT_H;
      end
      WAIT_H: begin
        if (i_resp) begin
          if (r_indx == LAST_IDX) begin
            w_state_next = IDLE;
            w_cmplt      = 1'b1;
          end else begin
            w_state_next = FETCH;
            w_indx_inc   = 1'b1;
          end
        end else if (w_tmo) begin
          w_state_next = FAULT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, timer, move index and latched inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_indx       <= 5'd0;
      r_move       <= 8'h00;
      r_solve_x    <= 3'd0;
      r_solve_y    <= 3'd0;
      r_tour_cmplt <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tour_cmplt <= w_cmplt;
      // Timer runs only in the waiting states and is zero on entry to each
      if (w_timing) r_timer <= r_timer + TMO_W'(1);
      else          r_timer <= '0;
      if (r_state == FETCH) r_move <= i_move;
      if (w_indx_clr)       r_indx <= 5'd0;
      else if (w_indx_inc)  r_indx <= r_indx + 5'd1;
      if (w_load_start) begin
        r_solve_x <= i_x_start;
        r_solve_y <= i_y_start;
      end
    end
  end

  // Command bus is driven only while offering a command, zero otherwise
  always_comb begin
    o_cmd = 16'h0000;
    if (r_state == VERT)      o_cmd = w_vert_cmd;
    else if (r_state == HORZ) o_cmd = w_horz_cmd;
  end

  assign o_solve_x    = r_solve_x;
  assign o_solve_y    = r_solve_y;
  assign o_solve_go   = (r_state == GO);
  assign o_indx       = r_indx;
  assign o_cmd_vld    = (r_state == VERT) || (r_state == HORZ);
  assign o_busy       = (r_state != IDLE) && (r_state != FAULT);
  assign o_fault      = (r_state == FAULT);
  assign o_tour_cmplt = r_tour_cmplt;

endmodule

// File: tb/tb_tour_seq.sv
// Directed + randomized bench for tour_seq with a move-table solver model.
module tb_tour_seq;

  localparam int NUM = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [2:0]  i_x_start, i_y_start;
  logic [2:0]  o_solve_x, o_solve_y;
  logic        o_solve_go;
  logic        i_solve_done;
  logic [4:0]  o_indx;
  logic [7:0]  w_move;
  logic [15:0] o_cmd;
  logic        o_cmd_vld;
  logic        i_cmd_rdy;
  logic        i_resp;
  logic        o_busy, o_tour_cmplt, o_fault;

  logic [7:0]  move_tab [0:31];
  int          checks = 0;
  int          failures = 0;
  int          n_accepts = 0;
  int          n_cmplt = 0;
  int          DXT [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int          DYT [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;

  // Solver model: move addressed combinationally by indx
  assign w_move = move_tab[o_indx];

  tour_seq #(.NUM_MOVES(NUM), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_x_start(i_x_start),
    .i_y_start(i_y_start), .o_solve_x(o_solve_x), .o_solve_y(o_solve_y),
    .o_solve_go(o_solve_go), .i_solve_done(i_solve_done), .o_indx(o_indx),
    .i_move(w_move), .o_cmd(o_cmd), .o_cmd_vld(o_cmd_vld), .i_cmd_rdy(i_cmd_rdy),
    .i_resp(i_resp), .o_busy(o_busy), .o_tour_cmplt(o_tour_cmplt), .o_fault(o_fault)
  );

  // Handshake and completion monitors
  always @(posedge clk) begin
    if (o_cmd_vld && i_cmd_rdy) n_accepts++;
    if (o_tour_cmplt) n_cmplt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: command derived from the move's knight displacement
  function automatic logic [15:0] model_cmd(input logic [7:0] mv, input bit y_leg);
    int b = 0;
    int d;
    for (int k = 0; k < 8; k++) if (mv == (8'd1 << k)) b = k;
    if (y_leg) begin
      d = DYT[b];
      return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'((d > 0) ? d : -d)};
    end
    d = DXT[b];
    return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'((d > 0) ? d : -d)};
  endfunction

  task automatic fill_random;
    for (int i = 0; i < 32; i++) move_tab[i] = (i < NUM) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
  endtask

  // Enter in the first cycle the command should be offered; leave in the
  // cycle after resp (or in the first WAIT cycle when send_resp is 0).
  task automatic do_leg(input logic [15:0] exp, input int idx, input bit y_leg,
                        input int rdy_wait, input int resp_wait, input bit send_resp);
    for (int k = 0; k < rdy_wait; k++) begin
      chk("bp_vld_held", o_cmd_vld, 1);
      chk("bp_cmd_stable", o_cmd, exp);
      i_cmd_rdy = 1'b0;
      i_resp = y_leg ? 1'($urandom_range(0, 1)) : 1'b0;
      step;
    end
    chk("cmd_vld", o_cmd_vld, 1);
    chk(y_leg ? "cmd_y" : "cmd_x", o_cmd, exp);
    i_resp = 1'b0;
    i_cmd_rdy = 1'b1;
    step;
    i_cmd_rdy = 1'b0;
    $display("cmd idx=%0d leg=%s cmd=%h rdy_wait=%0d", idx, y_leg ? "Y" : "X", exp, rdy_wait);
    chk("accept_first_rdy", o_cmd_vld, 0);
    if (send_resp) begin
      repeat (resp_wait - 1) step;
      i_resp = 1'b1;
      step;
      i_resp = 1'b0;
    end
  endtask

  task automatic run_tour(input logic [2:0] sx, input logic [2:0] sy,
                          input int stop_idx, input bit rand_hs);
    int a0 = n_accepts;
    int c0 = n_cmplt;
    int rw, pw;
    i_x_start = sx; i_y_start = sy; i_start = 1'b1;
    step;
    i_start = 1'b0;
    chk("launch_go", o_solve_go, 1);
    chk("launch_sx", o_solve_x, sx);
    chk("launch_sy", o_solve_y, sy);
    chk("launch_fault_clr", o_fault, 0);
    step;
    chk("go_one_cycle", o_solve_go, 0);
    repeat (9) step;
    i_solve_done = 1'b1;
    step;
    i_solve_done = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      chk("fetch_indx", o_indx, i);
      chk("fetch_no_vld", o_cmd_vld, 0);
      step;
      rw = rand_hs ? ((i == 0) ? 5 : int'($urandom_range(0, 5))) : 0;
      pw = rand_hs ? int'($urandom_range(1, 6)) : 3;
      do_leg(model_cmd(move_tab[i], 1'b1), i, 1'b1, rw, pw, 1'b1);
      rw = rand_hs ? int'($urandom_range(0, 5)) : 0;
      pw = rand_hs ? int'($urandom_range(1, 6)) : 3;
      do_leg(model_cmd(move_tab[i], 1'b0), i, 1'b0, rw, pw, i != stop_idx);
      if (i == stop_idx) return;
    end
    chk("cmplt_pulse", o_tour_cmplt, 1);
    chk("end_busy", o_busy, 0);
    chk("end_fault", o_fault, 0);
    chk("cmd_count", n_accepts - a0, 2 * NUM);
    step;
    chk("cmplt_one_cycle", o_tour_cmplt, 0);
    chk("cmplt_count", n_cmplt - c0, 1);
  endtask

  task automatic launch_to_fetch(input logic [7:0] mv0);
    move_tab[0] = mv0;
    i_start = 1'b1;
    step;
    i_start = 1'b0;
    step;
    i_solve_done = 1'b1;
    step;
    i_solve_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_go"}, o_solve_go, 0);
    chk({tag, "_vld"}, o_cmd_vld, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_cmplt"}, o_tour_cmplt, 0);
    chk({tag, "_fault"}, o_fault, 0);
    chk({tag, "_indx"}, o_indx, 0);
    chk({tag, "_cmd"}, o_cmd, 0);
    chk({tag, "_sx"}, o_solve_x, 0);
    chk({tag, "_sy"}, o_solve_y, 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_x_start = 3'd0; i_y_start = 3'd0;
    i_solve_done = 1'b0; i_cmd_rdy = 1'b0; i_resp = 1'b0;
    fill_random();
    move_tab[0] = 8'h01;
    move_tab[1] = 8'h08;
    repeat (3) step;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step;

    // Nominal tour from (2,2), zero-wait ready, resp 3 cycles after accept
    run_tour(3'd2, 3'd2, NUM, 1'b0);

    // Randomized backpressure and response timing
    fill_random();
    run_tour(3'd5, 3'd1, NUM, 1'b1);

    // Solver timeout: solve_go in cycle 0, fault visible in cycle 16
    i_x_start = 3'd4; i_y_start = 3'd6; i_start = 1'b1;
    step;
    i_start = 1'b0;
    chk("tmo_go", o_solve_go, 1);
    repeat (15) step;
    chk("tmo_c15_fault", o_fault, 0);
    chk("tmo_c15_busy", o_busy, 1);
    step;
    chk("tmo_c16_fault", o_fault, 1);
    chk("tmo_c16_busy", o_busy, 0);
    chk("tmo_c16_vld", o_cmd_vld, 0);
    i_x_start = 3'd1; i_y_start = 3'd3; i_start = 1'b1;
    step;
    i_start = 1'b0;
    chk("restart_fault_clr", o_fault, 0);
    chk("restart_go", o_solve_go, 1);
    chk("restart_sx", o_solve_x, 1);
    chk("restart_sy", o_solve_y, 3);
    step;
    // Still in SOLVE: feed an all-zero move
    move_tab[0] = 8'h00;
    i_solve_done = 1'b1;
    step;
    i_solve_done = 1'b0;
    chk("ill00_fetch_vld", o_cmd_vld, 0);
    step;
    chk("ill00_fault", o_fault, 1);
    chk("ill00_vld", o_cmd_vld, 0);
    launch_to_fetch(8'h81);
    chk("ill81_fetch_vld", o_cmd_vld, 0);
    step;
    chk("ill81_fault", o_fault, 1);
    chk("ill81_vld", o_cmd_vld, 0);

    // Response timeout in WAIT_V
    launch_to_fetch(8'h20);
    step;
    do_leg(model_cmd(8'h20, 1'b1), 0, 1'b1, 0, 1, 1'b0);
    repeat (14) step;
    chk("wtmo_c15_fault", o_fault, 0);
    step;
    chk("wtmo_c16_fault", o_fault, 1);
    chk("wtmo_c16_busy", o_busy, 0);

    // Reset while in WAIT_H at indx 7
    fill_random();
    run_tour(3'd7, 3'd0, 7, 1'b1);
    chk("wh_indx7", o_indx, 7);
    chk("wh_busy", o_busy, 1);
    rst = 1'b1;
    step;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    step;

    // start while busy is ignored
    i_x_start = 3'd3; i_y_start = 3'd4; i_start = 1'b1;
    step;
    i_start = 1'b0;
    chk("ign_go", o_solve_go, 1);
    step;
    i_x_start = 3'd5; i_y_start = 3'd6; i_start = 1'b1;
    step;
    i_start = 1'b0;
    chk("ign_no_go", o_solve_go, 0);
    chk("ign_sx", o_solve_x, 3);
    chk("ign_sy", o_solve_y, 4);
    chk("ign_busy", o_busy, 1);
    step;
    chk("ign_no_go2", o_solve_go, 0);
    rst = 1'b1;
    step;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
